sdram_frame_arbiter: RTL and testbench
======================================

// Module: sdram_frame_arbiter
// PURPOSE
//  Burst scheduler sitting directly upstream of the SDRAM command core (SDRAM_TOP).
//  Watches write-FIFO fill (camera side) and read-FIFO room (VGA side).
//  Issues one 256-word burst request at a time (write_en or read_en) with a stable addr/bank.
//  Triple-buffers frames across SDRAM banks 0..2, so the reader never reads the bank being written.
// PARAMETERS
//  BURST_LEN    256    words per burst; also the addr increment per completed burst
//  FRAME_WORDS  76800  words per frame; must be a multiple of BURST_LEN
//  RD_LOW       128    read burst is allowed only while rd_fifo_usedw < RD_LOW
//  ADDR_W       20     width of the word address within a bank
// PORTS
//  S_CLK          in   1       system clock
//  RST_N          in   1       asynchronous active-low reset
//  wr_fifo_usedw  in   9       write-FIFO used words (camera -> SDRAM)
//  rd_fifo_usedw  in   9       read-FIFO used words (SDRAM -> VGA)
//  vga_rd_req     in   1       display side wants frame data
//  write_ack      in   1       1-cycle pulse: write burst finished
//  read_ack       in   1       1-cycle pulse: read burst finished
//  write_en       out  1       write burst request, level, held until write_ack
//  read_en        out  1       read burst request, level, held until read_ack
//  addr           out  ADDR_W  burst start word address
//  bank           out  2       burst bank
//  frame_valid    out  1       at least one complete frame has been written
// BEHAVIOUR
//  Reset (async, RST_N=0). All outputs 0. Internal state:
//   - state = IDLE; wr_addr = rd_addr = 0
//   - wr_bank = 0, rd_bank = 2; done_bank = 0; last_grant = READ
//  State machine: IDLE, WRITE, READ. All outputs are registered.
//  Pending conditions:
//   - wr_pend = (wr_fifo_usedw >= BURST_LEN)
//   - rd_pend = vga_rd_req & frame_valid & (rd_fifo_usedw < RD_LOW)
//  IDLE grant:
//   - only wr_pend -> WRITE; only rd_pend -> READ
//   - both pending -> the opposite of last_grant (round robin)
//   - on the grant edge: set write_en or read_en; drive addr/bank; update last_grant
//   - the enable is visible the cycle after the pending condition is sampled
//  WRITE:
//   - addr = wr_addr and bank = wr_bank, both stable while write_en = 1
//   - on write_ack: write_en <= 0, state <= IDLE, wr_addr += BURST_LEN
//  READ: same as WRITE, using rd_addr/rd_bank, read_en and read_ack.
//  Acks outside their matching state are ignored. write_en and read_en are never both 1.
//  After every burst, IDLE lasts at least 1 cycle.
//  Write frame end (ack when wr_addr + BURST_LEN == FRAME_WORDS):
//   - wr_addr <= 0; done_bank <= wr_bank; frame_valid <= 1 (sticky until reset)
//   - wr_bank <= 3 - wr_bank - rd_bank (the third bank)
//  Read frame start (grant into READ while rd_addr == 0):
//   - if frame_valid and done_bank != wr_bank, then rd_bank <= done_bank before addr/bank are driven
//   - otherwise rd_bank is kept, so the previous frame repeats
//  Read frame end: rd_addr wraps to 0.
//  Invariants:
//   - wr_bank != rd_bank at all times; bank 3 is never used
//   - address arithmetic is unsigned ADDR_W bits; FRAME_WORDS <= 2^ADDR_W
//  RST_N low mid-burst: enables drop immediately. The in-flight burst is abandoned; no ack is expected.
// TESTING  (FRAME_WORDS = 1024, i.e. 4 bursts per frame)
//  1. Reset, then wr_fifo_usedw = 256, vga_rd_req = 0:
//     write_en = 1 next cycle, addr = 0, bank = 0; ack -> next burst addr = 256.
//  2. Four write acks:
//     frame_valid = 1, done_bank = 0, wr_bank = 1; the 5th write goes to addr 0, bank 1.
//  3. Then vga_rd_req = 1, rd_fifo_usedw = 0, wr_fifo_usedw = 300:
//     grants alternate W, R, W, R; the first read uses bank 0, addr 0.
//  4. rd_fifo_usedw = 200 with vga_rd_req = 1: read_en never asserts; writes continue.
//  5. Read a full frame before any new write frame completes: the next read frame repeats bank 0.
//     When a write frame ends (wr_bank 1 -> 2), the next read frame uses bank 1.
//  6. Pulse RST_N low while write_en = 1:
//     all outputs 0 asynchronously; after release the first write goes to addr 0, bank 0.
//     Spurious read_ack during WRITE is ignored.

Source files
------------

// File: rtl/sdram_frame_arbiter.sv
// Burst scheduler in front of the SDRAM command core: grants one 256-word write or read
// burst at a time and triple-buffers frames across banks 0..2.
module sdram_frame_arbiter #(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned RD_LOW      = 128,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic [8:0]        wr_fifo_usedw,
  input  logic [8:0]        rd_fifo_usedw,
  input  logic              vga_rd_req,
  input  logic              write_ack,
  input  logic              read_ack,
  output logic              write_en,
  output logic              read_en,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        bank,
  output logic              frame_valid
);

  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FRAME_WORDS - BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        wr_bank_q, wr_bank_d;
  logic [1:0]        rd_bank_q, rd_bank_d;
  logic [1:0]        done_bank_q, done_bank_d;
  logic              last_read_q, last_read_d;
  logic              write_en_q, write_en_d;
  logic              read_en_q, read_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        bank_q, bank_d;
  logic              frame_valid_q, frame_valid_d;

  logic              wr_pend;
  logic              rd_pend;
  logic [1:0]        rd_bank_sel;

  assign wr_pend = 32'(wr_fifo_usedw) >= BURST_LEN;
  assign rd_pend = vga_rd_req & frame_valid_q & (32'(rd_fifo_usedw) < RD_LOW);

  // A new read frame switches to the latest finished frame unless it is still being written.
  assign rd_bank_sel = ((rd_addr_q == '0) && frame_valid_q && (done_bank_q != wr_bank_q))
                       ? done_bank_q : rd_bank_q;

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_bank_q     <= 2'd0;
      rd_bank_q     <= 2'd2;
      done_bank_q   <= 2'd0;
      last_read_q   <= 1'b1;
      write_en_q    <= 1'b0;
      read_en_q     <= 1'b0;
      addr_q        <= '0;
      bank_q        <= 2'd0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      done_bank_q   <= done_bank_d;
      last_read_q   <= last_read_d;
      write_en_q    <= write_en_d;
      read_en_q     <= read_en_d;
      addr_q        <= addr_d;
      bank_q        <= bank_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    done_bank_d   = done_bank_q;
    last_read_d   = last_read_q;
    write_en_d    = write_en_q;
    read_en_d     = read_en_q;
    addr_d        = addr_q;
    bank_d        = bank_q;
    frame_valid_d = frame_valid_q;

    case (state_q)
      ST_IDLE: begin
        // Round robin only matters when both sides are pending.
        if (wr_pend && (!rd_pend || last_read_q)) begin
          state_d     = ST_WRITE;
          write_en_d  = 1'b1;
          addr_d      = wr_addr_q;
          bank_d      = wr_bank_q;
          last_read_d = 1'b0;
        end else if (rd_pend) begin
          state_d     = ST_READ;
          read_en_d   = 1'b1;
          addr_d      = rd_addr_q;
          bank_d      = rd_bank_sel;
          rd_bank_d   = rd_bank_sel;
          last_read_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (write_ack) begin
          write_en_d = 1'b0;
          state_d    = ST_IDLE;
          if (wr_addr_q == LAST_A) begin
            wr_addr_d     = '0;
            done_bank_d   = wr_bank_q;
            frame_valid_d = 1'b1;
            wr_bank_d     = 2'd3 - wr_bank_q - rd_bank_q;
          end else begin
            wr_addr_d = wr_addr_q + BURST_A;
          end
        end
      end
      ST_READ: begin
        if (read_ack) begin
          read_en_d = 1'b0;
          state_d   = ST_IDLE;
          rd_addr_d = (rd_addr_q == LAST_A) ? '0 : rd_addr_q + BURST_A;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
      end
    endcase
  end

  assign write_en    = write_en_q;
  assign read_en     = read_en_q;
  assign addr        = addr_q;
  assign bank        = bank_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench for sdram_frame_arbiter: directed scenarios then random traffic,
// compared against a burst-level model of the frame buffering rules.
module tb_sdram_frame_arbiter;

  localparam int unsigned BL  = 256;
  localparam int unsigned FW  = 1024;
  localparam int unsigned RDL = 128;
  localparam int unsigned AW  = 20;

  logic          S_CLK = 1'b0;
  logic          RST_N;
  logic [8:0]    wr_fifo_usedw;
  logic [8:0]    rd_fifo_usedw;
  logic          vga_rd_req;
  logic          write_ack;
  logic          read_ack;
  logic          write_en;
  logic          read_en;
  logic [AW-1:0] addr;
  logic [1:0]    bank;
  logic          frame_valid;

  sdram_frame_arbiter #(
    .BURST_LEN  (BL),
    .FRAME_WORDS(FW),
    .RD_LOW     (RDL),
    .ADDR_W     (AW)
  ) dut (
    .S_CLK        (S_CLK),
    .RST_N        (RST_N),
    .wr_fifo_usedw(wr_fifo_usedw),
    .rd_fifo_usedw(rd_fifo_usedw),
    .vga_rd_req   (vga_rd_req),
    .write_ack    (write_ack),
    .read_ack     (read_ack),
    .write_en     (write_en),
    .read_en      (read_en),
    .addr         (addr),
    .bank         (bank),
    .frame_valid  (frame_valid)
  );

  always #5 S_CLK = ~S_CLK;

  int errors = 0;
  int checks = 0;

  // Frame-buffer model: addresses, which bank holds what, and who was granted last.
  int m_wr_addr, m_rd_addr, m_wr_bank, m_rd_bank, m_done_bank, m_fv, m_last_read;
  int exp_addr, exp_bank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_addr = 0; m_rd_addr = 0;
    m_wr_bank = 0; m_rd_bank = 2; m_done_bank = 0;
    m_fv = 0; m_last_read = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   32'(write_en),    0);
    chk({tag, "_re"},   32'(read_en),     0);
    chk({tag, "_addr"}, 32'(addr),        0);
    chk({tag, "_bank"}, 32'(bank),        0);
    chk({tag, "_fv"},   32'(frame_valid), 0);
  endtask

  // Apply inputs in IDLE, then check one cycle later which burst (if any) was granted.
  task automatic idle_step(input int wr_u, input int rd_u, input int req, output int g);
    bit wp, rp;
    wr_fifo_usedw = 9'(wr_u);
    rd_fifo_usedw = 9'(rd_u);
    vga_rd_req    = 1'(req);
    wp = (wr_u >= BL);
    rp = (req != 0) && (m_fv != 0) && (rd_u < RDL);
    if (wp && rp)  g = (m_last_read != 0) ? 1 : 2;
    else if (wp)   g = 1;
    else if (rp)   g = 2;
    else           g = 0;
    @(negedge S_CLK);
    chk("grant_we",    32'(write_en),    32'(g == 1));
    chk("grant_re",    32'(read_en),     32'(g == 2));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    if (g == 1) begin
      m_last_read = 0;
      exp_addr = m_wr_addr;
      exp_bank = m_wr_bank;
    end else if (g == 2) begin
      m_last_read = 1;
      if (m_rd_addr == 0 && m_fv != 0 && m_done_bank != m_wr_bank) m_rd_bank = m_done_bank;
      exp_addr = m_rd_addr;
      exp_bank = m_rd_bank;
    end
    if (g != 0) begin
      chk("grant_addr", 32'(addr), 32'(exp_addr));
      chk("grant_bank", 32'(bank), 32'(exp_bank));
    end
  endtask

  // Hold the burst for some cycles (optionally with a wrong-kind ack), then ack it.
  task automatic finish_burst(input int g, input int hold, input int spur);
    int third;
    for (int i = 0; i < hold; i++) begin
      if (spur != 0) begin
        if (g == 1) read_ack = 1'b1;
        else        write_ack = 1'b1;
      end
      @(negedge S_CLK);
      read_ack  = 1'b0;
      write_ack = 1'b0;
      chk("hold_en",    32'(g == 1 ? write_en : read_en), 1);
      chk("hold_other", 32'(g == 1 ? read_en : write_en), 0);
      chk("hold_addr",  32'(addr), 32'(exp_addr));
      chk("hold_bank",  32'(bank), 32'(exp_bank));
    end
    if (g == 1) write_ack = 1'b1;
    else        read_ack  = 1'b1;
    @(negedge S_CLK);
    write_ack = 1'b0;
    read_ack  = 1'b0;
    chk("gap_we", 32'(write_en), 0);
    chk("gap_re", 32'(read_en),  0);
    if (g == 1) begin
      m_wr_addr += BL;
      if (m_wr_addr == FW) begin
        m_wr_addr   = 0;
        m_done_bank = m_wr_bank;
        m_fv        = 1;
        third = 0;
        for (int b = 0; b < 3; b++) if (b != m_wr_bank && b != m_rd_bank) third = b;
        m_wr_bank = third;
      end
    end else begin
      m_rd_addr = (m_rd_addr + BL) % FW;
    end
  endtask

  task automatic burst(input int wr_u, input int rd_u, input int req, output int g);
    idle_step(wr_u, rd_u, req, g);
    if (g != 0) finish_burst(g, 1, 0);
  endtask

  initial begin
    int g;
    int first;
    RST_N = 1'b0;
    wr_fifo_usedw = '0; rd_fifo_usedw = '0; vga_rd_req = 1'b0;
    write_ack = 1'b0; read_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge S_CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;

    // First write burst and address advance
    idle_step(256, 0, 0, g);
    chk("t1_addr0", 32'(addr), 0);
    chk("t1_bank0", 32'(bank), 0);
    finish_burst(g, 2, 0);
    idle_step(256, 0, 0, g);
    chk("t1_addr1", 32'(addr), 256);
    finish_burst(g, 0, 0);

    // Complete the first frame; the next write frame moves to bank 1
    burst(256, 0, 0, g);
    burst(256, 0, 0, g);
    chk("t2_fv", 32'(frame_valid), 1);
    idle_step(300, 0, 0, g);
    chk("t2_addr", 32'(addr), 0);
    chk("t2_bank", 32'(bank), 1);
    finish_burst(g, 1, 0);

    // Both pending: grants alternate, first read from bank 0 addr 0
    first = 1;
    for (int i = 0; i < 4; i++) begin
      idle_step(300, 0, 1, g);
      if (g == 2 && first != 0) begin
        chk("t3_rd_addr", 32'(addr), 0);
        chk("t3_rd_bank", 32'(bank), 0);
        first = 0;
      end
      if (g != 0) finish_burst(g, 1, 0);
    end

    // Read FIFO too full: no read grant, nothing else pending either
    for (int i = 0; i < 3; i++) begin
      idle_step(0, 200, 1, g);
      chk("t4_no_read", 32'(read_en), 0);
    end

    // Reset during a write burst drops everything at once
    idle_step(300, 0, 0, g);
    #2 RST_N = 1'b0;
    #1 chk_all_zero("t6_async");
    wr_fifo_usedw = '0; vga_rd_req = 1'b0;
    @(negedge S_CLK);
    RST_N = 1'b1;
    model_reset();
    idle_step(256, 0, 0, g);
    chk("t6_addr", 32'(addr), 0);
    chk("t6_bank", 32'(bank), 0);
    finish_burst(g, 3, 1);

    // Finish frame in bank 0, read it twice, then switch after the next frame lands
    for (int i = 0; i < 3; i++) burst(256, 0, 0, g);
    for (int i = 0; i < 4; i++) begin
      idle_step(0, 0, 1, g);
      if (i == 0) chk("t5_rd1_bank", 32'(bank), 0);
      if (g != 0) finish_burst(g, 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      idle_step(0, 0, 1, g);
      if (i == 0) chk("t5_repeat_bank", 32'(bank), 0);
      if (g != 0) finish_burst(g, 1, 0);
    end
    for (int i = 0; i < 4; i++) burst(256, 0, 0, g);
    idle_step(0, 0, 1, g);
    chk("t5_new_rd_bank", 32'(bank), 1);
    chk("t5_new_rd_addr", 32'(addr), 0);
    if (g != 0) finish_burst(g, 1, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      idle_step(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), g);
      if (g != 0) finish_burst(g, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
